// File: rtl/tag_compare_nway.sv
// tag_compare_nway: N-way set-associative tag comparator for the DRAM cache controller.
//
// Joins one {write, tid, addr} request with the WAYS tag entries read for its set. It produces
// a decision record (hit/miss, way, dirty-victim eviction) and, where the set must change, a
// tag-update record for the fill path. Entries are packed as {VALID, DIRTY, TAG}.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req_valid_i/req_ready_o  request channel {req_write_i, req_tid_i, req_addr_i}
//   tag_valid_i/tag_ready_o  tag-read response, way w at tag_data_i[w*ENT_W +: ENT_W]
//   res_valid_o/res_ready_i  decision {hit, write, way, tid, addr, evict, evict_addr}
//   upd_valid_o/upd_ready_i  tag update {upd_addr_o, upd_way_o, upd_entry_o}
//   multihit_o               sticky flag: more than one valid way matched a lookup
//   hit_cnt_o, miss_cnt_o    saturating lookup counters
module tag_compare_nway #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned TID_WIDTH    = 4,
  parameter int unsigned INDEX_WIDTH  = 10,
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned WAYS         = 4,
  parameter int unsigned CNT_WIDTH    = 32,
  localparam int unsigned WAY_W       = $clog2(WAYS),
  localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int unsigned ENT_W       = TAG_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [TID_WIDTH-1:0]  req_tid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  tag_valid_i,
  output logic                  tag_ready_o,
  input  logic [WAYS*ENT_W-1:0] tag_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  res_hit_o,
  output logic                  res_write_o,
  output logic [WAY_W-1:0]      res_way_o,
  output logic [TID_WIDTH-1:0]  res_tid_o,
  output logic [ADDR_WIDTH-1:0] res_addr_o,
  output logic                  res_evict_o,
  output logic [ADDR_WIDTH-1:0] res_evict_addr_o,
  output logic                  upd_valid_o,
  input  logic                  upd_ready_i,
  output logic [ADDR_WIDTH-1:0] upd_addr_o,
  output logic [WAY_W-1:0]      upd_way_o,
  output logic [ENT_W-1:0]      upd_entry_o,
  output logic                  multihit_o,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  typedef enum logic [1:0] {StIdle, StDec, StOut} state_e;

  state_e state_q, state_d;

  // Captured request and tag set
  logic                  req_write_q, req_write_d;
  logic [TID_WIDTH-1:0]  req_tid_q, req_tid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WAYS*ENT_W-1:0] tag_data_q, tag_data_d;

  // Registered outputs
  logic                  res_valid_q, res_valid_d;
  logic                  res_hit_q, res_hit_d;
  logic                  res_write_q, res_write_d;
  logic [WAY_W-1:0]      res_way_q, res_way_d;
  logic [TID_WIDTH-1:0]  res_tid_q, res_tid_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic                  res_evict_q, res_evict_d;
  logic [ADDR_WIDTH-1:0] res_evict_addr_q, res_evict_addr_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [ADDR_WIDTH-1:0] upd_addr_q, upd_addr_d;
  logic [WAY_W-1:0]      upd_way_q, upd_way_d;
  logic [ENT_W-1:0]      upd_entry_q, upd_entry_d;
  logic                  multihit_q, multihit_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
  logic [WAY_W-1:0]      rr_q, rr_d;

  // Lookup decode, evaluated on the captured set
  logic [TAG_WIDTH-1:0]   addr_tag;
  logic [INDEX_WIDTH-1:0] addr_index;
  logic [TAG_WIDTH-1:0]   way_tag [WAYS];
  logic [WAYS-1:0]        way_valid, way_dirty, match;
  logic [WAY_W:0]         match_cnt;
  logic                   hit, any_invalid, evict;
  logic [WAY_W-1:0]       hit_way, inv_way, victim;
  logic                   accept;

  assign addr_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign addr_index = req_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];

  always_comb begin
    match_cnt   = '0;
    hit_way     = '0;
    inv_way     = '0;
    any_invalid = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      way_valid[w] = tag_data_q[w*ENT_W + ENT_W - 1];
      way_dirty[w] = tag_data_q[w*ENT_W + ENT_W - 2];
      way_tag[w]   = tag_data_q[w*ENT_W +: TAG_WIDTH];
      match[w]     = way_valid[w] && (way_tag[w] == addr_tag);
      match_cnt    = match_cnt + (WAY_W+1)'(match[w]);
    end
    // Descending scan so the lowest matching / invalid way wins
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!way_valid[w]) begin
        inv_way     = WAY_W'(w);
        any_invalid = 1'b1;
      end
    end
    hit    = |match;
    victim = any_invalid ? inv_way : rr_q;
    evict  = !hit && way_valid[victim] && way_dirty[victim];
  end

  // Both channels are consumed together or not at all
  assign accept      = (state_q == StIdle) && req_valid_i && tag_valid_i && !rst;
  assign req_ready_o = accept;
  assign tag_ready_o = accept;

  always_comb begin
    state_d          = state_q;
    req_write_d      = req_write_q;
    req_tid_d        = req_tid_q;
    req_addr_d       = req_addr_q;
    tag_data_d       = tag_data_q;
    res_valid_d      = res_valid_q;
    res_hit_d        = res_hit_q;
    res_write_d      = res_write_q;
    res_way_d        = res_way_q;
    res_tid_d        = res_tid_q;
    res_addr_d       = res_addr_q;
    res_evict_d      = res_evict_q;
    res_evict_addr_d = res_evict_addr_q;
    upd_valid_d      = upd_valid_q;
    upd_addr_d       = upd_addr_q;
    upd_way_d        = upd_way_q;
    upd_entry_d      = upd_entry_q;
    multihit_d       = multihit_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    rr_d             = rr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          req_write_d = req_write_i;
          req_tid_d   = req_tid_i;
          req_addr_d  = req_addr_i;
          tag_data_d  = tag_data_i;
          state_d     = StDec;
        end
      end

      StDec: begin
        res_valid_d      = 1'b1;
        res_hit_d        = hit;
        res_write_d      = req_write_q;
        res_way_d        = hit ? hit_way : victim;
        res_tid_d        = req_tid_q;
        res_addr_d       = req_addr_q;
        res_evict_d      = evict;
        res_evict_addr_d = {way_tag[victim], addr_index, {OFFSET_WIDTH{1'b0}}};
        // A read hit leaves the set untouched; every other case rewrites one way with the
        // request tag (equal to the hit way's tag on a write hit), dirty iff it was a write.
        upd_valid_d      = req_write_q || !hit;
        upd_addr_d       = req_addr_q;
        upd_way_d        = hit ? hit_way : victim;
        upd_entry_d      = {1'b1, req_write_q, addr_tag};
        if (match_cnt > (WAY_W+1)'(1)) multihit_d = 1'b1;
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
          // Round-robin only advances when it actually chose the victim
          if (!any_invalid) rr_d = rr_q + WAY_W'(1);
        end
        state_d = StOut;
      end

      StOut: begin
        if (res_ready_i) res_valid_d = 1'b0;
        if (upd_ready_i) upd_valid_d = 1'b0;
        if (!res_valid_d && !upd_valid_d) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      req_write_q      <= 1'b0;
      req_tid_q        <= '0;
      req_addr_q       <= '0;
      tag_data_q       <= '0;
      res_valid_q      <= 1'b0;
      res_hit_q        <= 1'b0;
      res_write_q      <= 1'b0;
      res_way_q        <= '0;
      res_tid_q        <= '0;
      res_addr_q       <= '0;
      res_evict_q      <= 1'b0;
      res_evict_addr_q <= '0;
      upd_valid_q      <= 1'b0;
      upd_addr_q       <= '0;
      upd_way_q        <= '0;
      upd_entry_q      <= '0;
      multihit_q       <= 1'b0;
      hit_cnt_q        <= '0;
      miss_cnt_q       <= '0;
      rr_q             <= '0;
    end else begin
      state_q          <= state_d;
      req_write_q      <= req_write_d;
      req_tid_q        <= req_tid_d;
      req_addr_q       <= req_addr_d;
      tag_data_q       <= tag_data_d;
      res_valid_q      <= res_valid_d;
      res_hit_q        <= res_hit_d;
      res_write_q      <= res_write_d;
      res_way_q        <= res_way_d;
      res_tid_q        <= res_tid_d;
      res_addr_q       <= res_addr_d;
      res_evict_q      <= res_evict_d;
      res_evict_addr_q <= res_evict_addr_d;
      upd_valid_q      <= upd_valid_d;
      upd_addr_q       <= upd_addr_d;
      upd_way_q        <= upd_way_d;
      upd_entry_q      <= upd_entry_d;
      multihit_q       <= multihit_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
      rr_q             <= rr_d;
    end
  end

  assign res_valid_o      = res_valid_q;
  assign res_hit_o        = res_hit_q;
  assign res_write_o      = res_write_q;
  assign res_way_o        = res_way_q;
  assign res_tid_o        = res_tid_q;
  assign res_addr_o       = res_addr_q;
  assign res_evict_o      = res_evict_q;
  assign res_evict_addr_o = res_evict_addr_q;
  assign upd_valid_o      = upd_valid_q;
  assign upd_addr_o       = upd_addr_q;
  assign upd_way_o        = upd_way_q;
  assign upd_entry_o      = upd_entry_q;
  assign multihit_o       = multihit_q;
  assign hit_cnt_o        = hit_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;

endmodule

// File: tb/tb_tag_compare_nway.sv
// Self-checking bench for tag_compare_nway (WAYS=4, 32-bit address, 16-bit tag).
module tb_tag_compare_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_tid;
  logic [31:0] req_addr;
  logic        tag_valid, tag_ready;
  logic [71:0] tag_data;
  logic        res_valid, res_ready, res_hit, res_write, res_evict;
  logic [1:0]  res_way;
  logic [3:0]  res_tid;
  logic [31:0] res_addr, res_evict_addr;
  logic        upd_valid, upd_ready;
  logic [31:0] upd_addr;
  logic [1:0]  upd_way;
  logic [17:0] upd_entry;
  logic        multihit;
  logic [31:0] hit_cnt, miss_cnt;

  tag_compare_nway dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_write_i      (req_write),
    .req_tid_i        (req_tid),
    .req_addr_i       (req_addr),
    .tag_valid_i      (tag_valid),
    .tag_ready_o      (tag_ready),
    .tag_data_i       (tag_data),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .res_hit_o        (res_hit),
    .res_write_o      (res_write),
    .res_way_o        (res_way),
    .res_tid_o        (res_tid),
    .res_addr_o       (res_addr),
    .res_evict_o      (res_evict),
    .res_evict_addr_o (res_evict_addr),
    .upd_valid_o      (upd_valid),
    .upd_ready_i      (upd_ready),
    .upd_addr_o       (upd_addr),
    .upd_way_o        (upd_way),
    .upd_entry_o      (upd_entry),
    .multihit_o       (multihit),
    .hit_cnt_o        (hit_cnt),
    .miss_cnt_o       (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [3:0]  tid;
    logic [31:0] addr;
    logic [71:0] tags;
    logic        hit;
    logic [1:0]  way;
    logic        evict;
    logic [31:0] evict_addr;
    logic        upd_valid;
    logic [17:0] upd_entry;
    logic        multihit;
    int          res_stall;
    int          upd_stall;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;

  function automatic logic [17:0] ent(input logic v, input logic d, input logic [15:0] t);
    return {v, d, t};
  endfunction

  function automatic logic [71:0] pack4(input logic [17:0] e0, input logic [17:0] e1,
                                        input logic [17:0] e2, input logic [17:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one lookup, push its expectation, then service both output channels with the
  // given stall counts and compare what comes out.
  task automatic run_vec(input vec_t v);
    vec_t        e;
    bit          res_done, upd_done, stable;
    bit          have_e;
    int          res_cyc, upd_cyc, lat;
    logic [75:0] res_snap;
    logic [51:0] upd_snap;
    res_done = 0;
    upd_done = !v.upd_valid;
    stable   = 1;
    have_e   = 0;
    res_cyc  = 0;
    upd_cyc  = 0;
    lat      = -1;
    res_snap = '0;
    upd_snap = '0;
    @(negedge clk);
    req_valid = 1'b1;
    tag_valid = 1'b1;
    req_write = v.write;
    req_tid   = v.tid;
    req_addr  = v.addr;
    tag_data  = v.tags;
    #1;
    chk("req_ready", {63'd0, req_ready}, 64'd1);
    chk("tag_ready", {63'd0, tag_ready}, 64'd1);
    @(posedge clk);
    #1;
    sb.push_back(v);
    req_valid = 1'b0;
    tag_valid = 1'b0;
    req_addr  = $urandom;
    tag_data  = {$urandom, $urandom, $urandom};
    for (int n = 0; n < 40 && !(res_done && upd_done); n++) begin
      @(negedge clk);
      res_ready = 1'b0;
      upd_ready = 1'b0;
      if (res_valid && !res_done) begin
        if (lat < 0) begin
          lat = n;
          res_snap = {res_hit, res_write, res_way, res_tid, res_addr, res_evict, res_evict_addr};
          if (sb.size() != 0) begin
            e = sb.pop_front();
            have_e = 1;
          end
        end else if ({res_hit, res_write, res_way, res_tid, res_addr, res_evict,
                      res_evict_addr} !== res_snap) begin
          stable = 0;
        end
        if (res_cyc >= v.res_stall && have_e) begin
          res_ready = 1'b1;
          res_done  = 1;
          chk("res_hit", {63'd0, res_hit}, {63'd0, e.hit});
          chk("res_way", {62'd0, res_way}, {62'd0, e.way});
          chk("res_write", {63'd0, res_write}, {63'd0, e.write});
          chk("res_tid", {60'd0, res_tid}, {60'd0, e.tid});
          chk("res_addr", {32'd0, res_addr}, {32'd0, e.addr});
          chk("res_evict", {63'd0, res_evict}, {63'd0, e.evict});
          if (e.evict) chk("res_evict_addr", {32'd0, res_evict_addr}, {32'd0, e.evict_addr});
        end
        res_cyc++;
      end else if (res_valid && res_done) begin
        chk("res_valid_drop", {63'd0, res_valid}, 64'd0);
      end
      if (upd_valid && !v.upd_valid) begin
        chk("upd_spurious", {63'd0, upd_valid}, 64'd0);
        upd_done = 1;
      end else if (upd_valid && !upd_done) begin
        if (upd_cyc == 0) upd_snap = {upd_addr, upd_way, upd_entry};
        else if ({upd_addr, upd_way, upd_entry} !== upd_snap) stable = 0;
        if (upd_cyc >= v.upd_stall) begin
          upd_ready = 1'b1;
          upd_done  = 1;
          chk("upd_addr", {32'd0, upd_addr}, {32'd0, v.addr});
          chk("upd_way", {62'd0, upd_way}, {62'd0, v.way});
          chk("upd_entry", {46'd0, upd_entry}, {46'd0, v.upd_entry});
        end
        upd_cyc++;
      end
    end
    chk("both_done", {62'd0, res_done, upd_done}, 64'd3);
    chk("latency", 64'(lat), 64'd1);
    chk("payload_stable", {63'd0, stable}, 64'd1);
    @(negedge clk);
    res_ready = 1'b0;
    upd_ready = 1'b0;
    chk("valids_idle", {62'd0, res_valid, upd_valid}, 64'd0);
    if (v.hit) exp_hits++;
    else exp_misses++;
    chk("hit_cnt", {32'd0, hit_cnt}, 64'(exp_hits));
    chk("miss_cnt", {32'd0, miss_cnt}, 64'(exp_misses));
    chk("multihit", {63'd0, multihit}, {63'd0, v.multihit});
  endtask

  initial begin
    vec_t vr;
    //             wr tid   addr          tags                                                     hit way ev evict_addr   upd upd_entry                 mh  rs us
    vecs[0] = '{1'b0, 4'd1, 32'h1234_5680,
                pack4(ent(1, 0, 16'h1111), ent(0, 0, 16'h0000), ent(1, 0, 16'h1234), ent(1, 1, 16'h2222)),
                1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 18'h0, 1'b0, 0, 0};
    vecs[1] = '{1'b1, 4'd2, 32'h1234_5680,
                pack4(ent(1, 0, 16'h1111), ent(0, 0, 16'h0000), ent(1, 0, 16'h1234), ent(1, 1, 16'h2222)),
                1'b1, 2'd2, 1'b0, 32'h0, 1'b1, ent(1, 1, 16'h1234), 1'b0, 0, 2};
    vecs[2] = '{1'b1, 4'd3, 32'h1234_5680,
                pack4(ent(1, 0, 16'hAAAA), ent(0, 1, 16'hBEEF), ent(1, 1, 16'h3333), ent(1, 0, 16'h4444)),
                1'b0, 2'd1, 1'b0, 32'h0, 1'b1, ent(1, 1, 16'h1234), 1'b0, 0, 0};
    vecs[3] = '{1'b0, 4'd4, 32'h1234_5680,
                pack4(ent(1, 1, 16'hBEEF), ent(1, 0, 16'h0001), ent(1, 0, 16'h0002), ent(1, 0, 16'h0003)),
                1'b0, 2'd0, 1'b1, 32'hBEEF_5680, 1'b1, ent(1, 0, 16'h1234), 1'b0, 0, 0};
    vecs[4] = '{1'b0, 4'd5, 32'h1234_5680,
                pack4(ent(1, 1, 16'hBEEF), ent(1, 0, 16'h0001), ent(1, 0, 16'h0002), ent(1, 0, 16'h0003)),
                1'b0, 2'd1, 1'b0, 32'h0, 1'b1, ent(1, 0, 16'h1234), 1'b0, 1, 1};
    vecs[5] = '{1'b0, 4'd6, 32'h1234_5680,
                pack4(ent(1, 0, 16'h0005), ent(1, 0, 16'h1234), ent(0, 0, 16'h1234), ent(1, 1, 16'h1234)),
                1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 18'h0, 1'b1, 0, 0};
    vecs[6] = '{1'b1, 4'd7, 32'hCAFE_0040,
                pack4(ent(0, 0, 16'h0000), ent(0, 1, 16'hCAFE), ent(0, 0, 16'h0000), ent(1, 1, 16'hCAFE)),
                1'b1, 2'd3, 1'b0, 32'h0, 1'b1, ent(1, 1, 16'hCAFE), 1'b1, 5, 0};
    vecs[7] = '{1'b1, 4'd8, 32'h0001_0000,
                pack4(ent(1, 0, 16'h0007), ent(1, 0, 16'h0008), ent(1, 1, 16'h0009), ent(1, 0, 16'h000A)),
                1'b0, 2'd2, 1'b1, 32'h0009_0000, 1'b1, ent(1, 1, 16'h0001), 1'b1, 0, 0};

    rst       = 1'b1;
    req_valid = 1'b0;
    tag_valid = 1'b0;
    req_write = 1'b0;
    req_tid   = '0;
    req_addr  = '0;
    tag_data  = '0;
    res_ready = 1'b0;
    upd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {55'd0, req_ready, tag_ready, res_valid, upd_valid, multihit, res_hit,
                        res_evict, res_way}, 64'd0);
    chk("rst_counters", {hit_cnt, miss_cnt}, 64'd0);
    rst = 1'b0;

    // Only one channel valid: nothing may be consumed
    @(negedge clk);
    tag_valid = 1'b1;
    tag_data  = vecs[0].tags;
    repeat (3) begin
      #1;
      chk("tag_only_ready", {62'd0, req_ready, tag_ready}, 64'd0);
      @(negedge clk);
    end
    tag_valid = 1'b0;
    req_valid = 1'b1;
    req_addr  = vecs[0].addr;
    #1;
    chk("req_only_ready", {62'd0, req_ready, tag_ready}, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("no_result", {62'd0, res_valid, upd_valid}, 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while the decision is pending
    vr = vecs[3];
    vr.tid = 4'd9;
    @(negedge clk);
    req_valid = 1'b1;
    tag_valid = 1'b1;
    req_write = vr.write;
    req_tid   = vr.tid;
    req_addr  = vr.addr;
    tag_data  = vr.tags;
    @(posedge clk);
    #1;
    sb.push_back(vr);
    req_valid = 1'b0;
    tag_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_res_valid", {63'd0, res_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_valids", {62'd0, res_valid, upd_valid}, 64'd0);
    chk("post_rst_state", {61'd0, multihit, req_ready, tag_ready}, 64'd0);
    chk("post_rst_counters", {hit_cnt, miss_cnt}, 64'd0);
    @(negedge clk);
    chk("post_rst_quiet", {62'd0, res_valid, upd_valid}, 64'd0);
    sb.delete();
    exp_hits   = 0;
    exp_misses = 0;

    // Victim pointer must be back at way 0
    run_vec(vr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
